// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory port arbiter (F = fetch, D = load/store).
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_F, OWN_D} owner_t;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned LAT_W  = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner choice between fetch and data requests.
// MEM_PORT_ARBITER_RR_EN selects round-robin ties; otherwise D-priority with starvation override.
module mem_arb_pick
  import mem_arb_pkg::*;
`ifndef MEM_PORT_ARBITER_RR_EN
#(
  parameter int unsigned MAX_WAIT = 4
)
`endif
(
  input  logic              f_req_i,
  input  logic              d_req_i,
`ifdef MEM_PORT_ARBITER_RR_EN
  input  owner_t            last_owner_i,
`else
  input  logic [WAIT_W-1:0] wait_cnt_i,
`endif
  output logic              grant_valid_c,
  output owner_t            grant_owner_c
);

  always_comb begin
    grant_valid_c = f_req_i | d_req_i;
    grant_owner_c = OWN_F;
    if (f_req_i && d_req_i) begin
`ifdef MEM_PORT_ARBITER_RR_EN
      // Last-granted port loses the tie
      grant_owner_c = (last_owner_i == OWN_F) ? OWN_D : OWN_F;
`else
      grant_owner_c = (wait_cnt_i >= WAIT_W'(MAX_WAIT)) ? OWN_F : OWN_D;
`endif
    end else if (d_req_i) begin
      grant_owner_c = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch (F) and load/store (D) via req/gnt/done.
// Optional build macro: MEM_PORT_ARBITER_RR_EN (round-robin ties instead of D-priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MAX_WAIT    = 4
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic                f_gnt,
  output logic                f_done,
  output logic [DATA_W-1:0]   f_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
  logic              f_done_q, f_done_d, d_done_q, d_done_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              busy_q, busy_d;
  logic              grant_valid;
  owner_t            grant_owner;

`ifdef MEM_PORT_ARBITER_RR_EN
  mem_arb_pick u_pick (
    .f_req_i       (f_req),
    .d_req_i       (d_req),
    .last_owner_i  (owner_q),
    .grant_valid_c (grant_valid),
    .grant_owner_c (grant_owner)
  );
`else
  logic [WAIT_W-1:0] wait_q, wait_d;

  mem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .f_req_i       (f_req),
    .d_req_i       (d_req),
    .wait_cnt_i    (wait_q),
    .grant_valid_c (grant_valid),
    .grant_owner_c (grant_owner)
  );

  // Fetch starvation counter, only updated while arbitrating in IDLE
  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE) begin
      if (!f_req || (grant_valid && grant_owner == OWN_F)) begin
        wait_d = '0;
      end else if (wait_q != '1) begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`endif

  // Next state; outputs are computed one cycle early and registered
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    lat_d       = lat_q;
    f_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    f_done_d    = 1'b0;
    d_done_d    = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_be_d    = '0;
    busy_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d  = ISSUE;
          owner_d  = grant_owner;
          busy_d   = 1'b1;
          mem_en_d = 1'b1;
          if (grant_owner == OWN_F) begin
            we_d       = 1'b0;
            f_gnt_d    = 1'b1;
            mem_addr_d = f_addr;
            mem_be_d   = '1;
          end else begin
            we_d        = d_we;
            d_gnt_d     = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_we ? d_be : '1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        lat_d   = LAT_W'(MEM_LATENCY - 1);
        busy_d  = 1'b1;
      end
      WAIT: begin
        busy_d = 1'b1;
        if (lat_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_F) begin
            f_done_d  = 1'b1;
            f_rdata_d = mem_rdata;
          end else begin
            d_done_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_F;
      we_q        <= 1'b0;
      lat_q       <= '0;
      f_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      lat_q       <= lat_d;
      f_gnt_q     <= f_gnt_d;
      d_gnt_q     <= d_gnt_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      busy_q      <= busy_d;
    end
  end

  assign f_gnt     = f_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign f_done    = f_done_q;
  assign d_done    = d_done_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency-1 instance plus a latency-3 instance.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req, d_req3, d_we;
  logic [31:0] f_addr, d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_be;

  logic        f_gnt, f_done, d_gnt, d_done, mem_en, mem_we, busy;
  logic [63:0] f_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [31:0] mem_addr;
  logic [7:0]  mem_be;

  logic        f_gnt3, f_done3, d_gnt3, d_done3, mem_en3, mem_we3, busy3;
  logic [63:0] f_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [31:0] mem_addr3;
  logic [7:0]  mem_be3;

  logic        p1_v, p2_v;
  logic [31:0] p1_a, p2_a;

  int total = 0;
  int bad   = 0;
  logic exp_d [6];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(1), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .MAX_WAIT(4)) dut3 (
    .clk(clk), .reset(rst_n),
    .f_req(1'b0), .f_addr(f_addr), .f_gnt(f_gnt3), .f_done(f_done3), .f_rdata(f_rdata3),
    .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt3), .d_done(d_done3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_be(mem_be3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  function automatic logic [63:0] data_of(input logic [31:0] a);
    if (a == 32'h100) return 64'hDEAD_BEEF;
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  // Memory models: read data valid exactly MEM_LATENCY cycles after mem_en, X otherwise
  always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? data_of(mem_addr) : 'x;

  always @(posedge clk) begin
    p1_v <= mem_en3 && !mem_we3;
    p1_a <= mem_addr3;
    p2_v <= p1_v;
    p2_a <= p1_a;
    mem_rdata3 <= p2_v ? data_of(p2_a) : 'x;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef MEM_PORT_ARBITER_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_req3 = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;

    // Reset state
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_gnt", {f_gnt, d_gnt, f_done, d_done}, 0);
    chk("rst_rdata", f_rdata | d_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Single fetch
    f_req = 1'b1; f_addr = 32'h100;
    tick();
    chk("f_gnt", f_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    chk("f_mem_en", mem_en, 1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we", mem_we, 0);
    chk("f_busy1", busy, 1);
    f_req = 1'b0;
    tick();
    chk("f_done_early", f_done, 0);
    chk("f_mem_en_off", mem_en, 0);
    tick();
    chk("f_done", f_done, 1);
    chk("f_rdata", f_rdata, 64'hDEAD_BEEF);
    chk("f_d_done", d_done, 0);
    tick();
    chk("f_busy_idle", busy, 0);
    chk("f_done_pulse", f_done, 0);

    // Store byte
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h208; d_wdata = 64'hAB; d_be = 8'h01;
    tick();
    chk("st_gnt", d_gnt, 1);
    chk("st_mem", {mem_en, mem_we, mem_be}, {1'b1, 1'b1, 8'h01});
    chk("st_wdata", mem_wdata, 64'hAB);
    chk("st_addr", mem_addr, 32'h208);
    d_req = 1'b0;
    tick();
    tick();
    chk("st_done", d_done, 1);
    chk("st_rdata", d_rdata, 0);
    tick();

    // Load with partial byte enables: memory still sees all ones
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 8'h0F;
    tick();
    chk("ld_mem_be", mem_be, 8'hFF);
    chk("ld_mem_we", mem_we, 0);
    d_req = 1'b0;
    tick();
    tick();
    chk("ld_done", d_done, 1);
    chk("ld_rdata", d_rdata, data_of(32'h40));
    tick();

    // Latency-3 load on second instance
    d_req3 = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) d_req3 = 1'b0;
      chk($sformatf("l3_busy_c%0d", c), busy3, (c <= 5) ? 1 : 0);
      chk($sformatf("l3_gnt_c%0d", c), {mem_en3, d_gnt3}, (c == 1) ? 2'b11 : 2'b00);
      chk($sformatf("l3_done_c%0d", c), d_done3, (c == 5) ? 1 : 0);
    end
    chk("l3_rdata", d_rdata3, data_of(32'h300));

    // Reset during WAIT of a load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
    tick();
    chk("mr_gnt", d_gnt, 1);
    d_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_outs", {busy, mem_en, d_gnt, d_done, f_gnt, f_done}, 0);
    chk("mr_rdata", d_rdata | f_rdata, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mr_after_c%0d", c), {d_done, busy}, 0);
    end

    // Contention: both held high continuously
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = 32'h180; d_addr = 32'h280;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("ct_gnt%0d", k), {f_gnt, d_gnt}, exp_d[k] ? 2'b01 : 2'b10);
      if (k == 5) begin
        f_req = 1'b0; d_req = 1'b0;
      end
      tick();
      tick();
      if (exp_d[k]) begin
        chk($sformatf("ct_done%0d", k), {d_done, f_done}, 2'b10);
        chk($sformatf("ct_rdata%0d", k), d_rdata, data_of(32'h280));
      end else begin
        chk($sformatf("ct_done%0d", k), {d_done, f_done}, 2'b01);
        chk($sformatf("ct_rdata%0d", k), f_rdata, data_of(32'h180));
      end
      tick();
    end
    tick();
    chk("ct_idle", {busy, mem_en}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction memory between two requesters: the instruction-fetch path (port F) and the load/store path (port D) of the multicycle RV64 core.
- Sequences each access through a fixed-latency memory and returns a completion pulse with read data.
- Replaces the per-state IMemRead/DMemRead strobes with a req/gnt/done handshake, so the control FSM waits on done instead of counting cycles.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 64, data width; byte-enable width is DATA_W/8
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..7
- MAX_WAIT, 4, consecutive cycles fetch may lose arbitration before it is forced to win; legal range 1..15

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  reset; one clock; reset is asynchronous and active-low (asserted at 0)
- f_req  in  1  fetch request; held high until f_gnt
- f_addr  in  ADDR_W  fetch address; reads only
- f_gnt  out  1  one-cycle pulse: fetch accepted
- f_done  out  1  one-cycle pulse: f_rdata valid
- f_rdata  out  DATA_W  fetch read data; held until the next f_done
- d_req  in  1  data request; held high until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables (sd=all, sw/sh/sb=subset)
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_done  out  1  one-cycle pulse: load data valid or store committed
- d_rdata  out  DATA_W  load data; held until the next d_done
- mem_en  out  1  memory access strobe, one cycle
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; wait counter 0; owner register = F; f_rdata and d_rdata = 0.
- IDLE: evaluate f_req and d_req.
  - Only one asserted: that port wins.
  - Both asserted: D wins, unless wait_cnt >= MAX_WAIT, in which case F wins.
  - A winner exists: next state ISSUE; latch the winner's owner, we, addr, wdata and be.
- ISSUE (1 cycle):
  - mem_en=1; mem_we/addr/wdata/be driven from the latched values; winner's gnt=1.
  - Loads: mem_be = all ones. Fetch: mem_we = 0.
  - Next state WAIT, with lat_cnt = MEM_LATENCY-1.
- WAIT: decrement lat_cnt; leave when lat_cnt==0. With MEM_LATENCY=1, WAIT lasts 1 cycle. Next state RESP.
- RESP (1 cycle):
  - Owner's done=1. For reads, the owner's rdata register captures mem_rdata.
  - Stores: done pulses, rdata unchanged.
  - Next state IDLE.
- Timing:
  - Request seen in IDLE at cycle 0: gnt at cycle 1, done at cycle 2+MEM_LATENCY.
  - Back-to-back throughput: one access per MEM_LATENCY+3 cycles.
- Wait counter:
  - Increments (saturating at 15) on each IDLE cycle where f_req=1 and D wins.
  - Clears when F is granted, or when f_req=0.
- Requests arriving or deasserting while not in IDLE are ignored until the return to IDLE.
- A requester dropping req before gnt causes no access (not an error).
- req high in the cycle of its own done: treated as a new request at the next IDLE.
- Reset mid-operation: the access is abandoned immediately; no gnt or done is produced afterwards. A write already issued on mem_en is not rolled back.
- Address alignment is not checked; misaligned addresses pass through unchanged.

Optional Feature:
- Macro MEM_PORT_ARBITER_RR_EN.
- Defined: both-requesting ties alternate round-robin; the last-granted port loses the next tie. MAX_WAIT and the wait counter are unused, with no starvation logic synthesized.
- Undefined: fixed D-priority with the MAX_WAIT starvation override, as above.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAIT, RESP}
  - typedef enum logic owner_t {OWN_F, OWN_D}
  - localparam for the wait-counter width (4)
- One natural sub-module: mem_arb_pick.
  - Combinational priority/round-robin choice.
  - Inputs: f_req, d_req, wait_cnt, last_owner.
  - Outputs: grant_valid, grant_owner.
  - Keeps the RR_EN variant isolated.

Test Plan:
- Single fetch, MEM_LATENCY=1, f_req=1, f_addr=0x100, memory returns 0xDEAD_BEEF -> f_gnt at cycle 1, mem_en with mem_addr=0x100 at cycle 1, f_done at cycle 3 with f_rdata=0xDEAD_BEEF; d_gnt/d_done stay 0.
- Store sb, d_we=1, d_addr=0x208, d_wdata=0xAB, d_be=0x01 -> one mem_en with mem_we=1, mem_be=0x01, mem_wdata=0xAB; d_done 2 cycles later; d_rdata unchanged.
- Contention, MAX_WAIT=4, f_req and d_req held high continuously with d_req re-raised after each d_done -> grants are D,D,D,D,F: fetch forced on its 5th losing IDLE; wait_cnt returns to 0 after f_gnt.
- MEM_LATENCY=3 load -> exactly 3 WAIT cycles; d_done exactly 5 cycles after the request; busy high for cycles 1..5.
- reset driven to 0 during WAIT of a load -> all outputs 0 within the same cycle; after release with no requests there is no d_done and busy=0.
- With MEM_PORT_ARBITER_RR_EN, both ports requesting continuously -> grants alternate F,D,F,D starting with D (owner reset value F counts as last granted).
